// File: rtl/branch_cmp_ctrl.sv
// ID-stage branch comparator controller: operand forwarding selects, load/ALU hazard stalls,
// beq/bne resolution, stall watchdog and branch statistics.
module branch_cmp_ctrl #(
  parameter int unsigned DELAY_SLOT = 1,
  parameter int unsigned MAX_STALL  = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_br,
  input  logic             id_bne,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_we,
  input  logic [4:0]       ex_wa,
  input  logic             mem_we,
  input  logic [4:0]       mem_wa,
  input  logic             mem_load,
  input  logic             w_we,
  input  logic [4:0]       w_wa,
  input  logic             equal,
  output logic [1:0]       sel_a1,
  output logic [1:0]       sel_a2,
  output logic             stall,
  output logic             br_taken,
  output logic             flush_if,
  output logic             err,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam int unsigned CtrW = $clog2(MAX_STALL + 2);
  localparam logic [CtrW-1:0] CtrMax = CtrW'(MAX_STALL);

  typedef enum logic {StIdle, StWait} state_t;

  state_t          state_q;
  logic [CtrW-1:0] stall_ctr_q;
  logic [CtrW-1:0] stall_ctr_nxt;
  logic            haz_rs, haz_rt;
  logic [1:0]      fwd_rs, fwd_rt;
  logic            resolve;

  // Returns {hazard, select} for one comparator operand.
  function automatic logic [2:0] fwd(input logic [4:0] r,
                                     input logic ex_we_f, input logic [4:0] ex_wa_f,
                                     input logic mem_we_f, input logic [4:0] mem_wa_f,
                                     input logic mem_load_f,
                                     input logic w_we_f, input logic [4:0] w_wa_f);
    logic [2:0] res;
    res = 3'b000;
    if (r == 5'd0) begin
      res = 3'b000;
    end else if (ex_we_f && (ex_wa_f == r)) begin
      res = 3'b100;
    end else if (mem_we_f && (mem_wa_f == r)) begin
      res = mem_load_f ? 3'b100 : 3'b001;
    end else if (w_we_f && (w_wa_f == r)) begin
      res = 3'b010;
    end
    return res;
  endfunction

  always_comb begin
    {haz_rs, fwd_rs} = fwd(id_rs, ex_we, ex_wa, mem_we, mem_wa, mem_load, w_we, w_wa);
    {haz_rt, fwd_rt} = fwd(id_rt, ex_we, ex_wa, mem_we, mem_wa, mem_load, w_we, w_wa);
    stall    = id_br & (haz_rs | haz_rt);
    sel_a1   = (id_br & ~haz_rs) ? fwd_rs : 2'd0;
    sel_a2   = (id_br & ~haz_rt) ? fwd_rt : 2'd0;
    resolve  = id_br & ~stall;
    br_taken = resolve & (id_bne ? ~equal : equal);
    flush_if = br_taken & (DELAY_SLOT == 0);
  end

  // Stall run length as it would be after this edge if the branch keeps stalling.
  always_comb begin
    stall_ctr_nxt = CtrW'(1);
    if (state_q == StWait) begin
      stall_ctr_nxt = (stall_ctr_q >= CtrMax) ? stall_ctr_q : stall_ctr_q + CtrW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      stall_ctr_q <= '0;
      err         <= 1'b0;
      br_cnt      <= '0;
      taken_cnt   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (id_br && stall) begin
            state_q     <= StWait;
            stall_ctr_q <= stall_ctr_nxt;
          end
        end
        StWait: begin
          if (id_br && stall) begin
            stall_ctr_q <= stall_ctr_nxt;
          end else begin
            state_q     <= StIdle;
            stall_ctr_q <= '0;
          end
        end
        default: begin
          state_q     <= StIdle;
          stall_ctr_q <= '0;
        end
      endcase
      if (id_br && stall && (stall_ctr_nxt >= CtrMax)) begin
        err <= 1'b1;
      end
      if (resolve) begin
        br_cnt <= br_cnt + CNT_W'(1);
        if (br_taken) begin
          taken_cnt <= taken_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
